// File: rtl/rsa_pkg.sv
// Shared constants and FSM state encoding for the RSA modular-exponentiation path.
package rsa_pkg;

  localparam int W_DEF  = 1024;
  localparam int EW_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SQ_ISSUE,
    SQ_WAIT,
    MUL_ISSUE,
    MUL_WAIT,
    NEXT,
    DONE
  } state_e;

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer; drives an external modular
// multiplier over its ds/ready handshake and captures the final power.
module modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int EW = EW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  base,
  input  logic [EW-1:0] exponent,
  input  logic [W-1:0]  modulus,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          mm_ds,
  output logic [W-1:0]  mm_mpand,
  output logic [W-1:0]  mm_mplier,
  output logic [W-1:0]  mm_modulus,
  input  logic          mm_ready,
  input  logic [W-1:0]  mm_product
);

  localparam int CW = $clog2(EW + 1);

  state_e        state_q, state_d;
  logic [EW-1:0] e_q, e_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  m_q, m_d;
  logic [W-1:0]  n_q, n_d;
  logic [W-1:0]  result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          guard_q, guard_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      e_q      <= '0;
      r_q      <= '0;
      m_q      <= '0;
      n_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      guard_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      e_q      <= e_d;
      r_q      <= r_d;
      m_q      <= m_d;
      n_q      <= n_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      guard_q  <= guard_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    e_d      = e_q;
    r_d      = r_q;
    m_d      = m_q;
    n_d      = n_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    guard_d  = 1'b0;
    mm_ds    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = base;
          e_d     = exponent;
          n_d     = modulus;
          cnt_d   = CW'(EW);
          state_d = SCAN;
        end
      end

      // Skip leading zeros; the first set bit seeds R with M without a multiply.
      SCAN: begin
        if (cnt_q == '0) begin
          r_d      = W'(1);
          result_d = W'(1);
          state_d  = DONE;
        end else begin
          e_d   = e_q << 1;
          cnt_d = cnt_q - CW'(1);
          if (e_q[EW-1]) begin
            r_d = m_q;
            if (cnt_q == CW'(1)) begin
              result_d = m_q;
              state_d  = DONE;
            end else begin
              state_d = SQ_ISSUE;
            end
          end
        end
      end

      SQ_ISSUE: begin
        if (mm_ready) begin
          mm_ds   = 1'b1;
          guard_d = 1'b1;
          state_d = SQ_WAIT;
        end
      end

      // E has already been shifted, so its MSB is the bit being processed.
      SQ_WAIT: begin
        if (!guard_q && mm_ready) begin
          r_d     = mm_product;
          state_d = e_q[EW-1] ? MUL_ISSUE : NEXT;
        end
      end

      MUL_ISSUE: begin
        if (mm_ready) begin
          mm_ds   = 1'b1;
          guard_d = 1'b1;
          state_d = MUL_WAIT;
        end
      end

      MUL_WAIT: begin
        if (!guard_q && mm_ready) begin
          r_d     = mm_product;
          state_d = NEXT;
        end
      end

      NEXT: begin
        e_d   = e_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = r_q;
          state_d  = DONE;
        end else begin
          state_d = SQ_ISSUE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign result     = result_q;
  assign mm_mpand   = r_q;
  assign mm_mplier  = (state_q == MUL_ISSUE || state_q == MUL_WAIT) ? m_q : r_q;
  assign mm_modulus = n_q;

endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

Square-and-multiply sequencer for RSA modular exponentiation. It computes `result = base^exponent mod modulus` by issuing a series of modular multiplications to the shift-add modular multiplier (`montgomery` in this design) over that block's `ds`/`ready` handshake. It sits directly upstream of the multiplier and owns operand selection, exponent scanning and result capture. The multiplier is instantiated beside it in the parent.

## Interface
Parameters:
- `W`, 1024: operand and modulus width. Must match the multiplier.
- `EW`, 1024: exponent width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request. Sampled only in IDLE.
- `base`  in  W  message or ciphertext. Must be `< modulus`.
- `exponent`  in  EW  e or d.
- `modulus`  in  W  N. Must be ≥ 2.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when `result` is valid.
- `result`  out  W  final value. Held until the next accepted `start`.
- `mm_ds`  out  1  start strobe to the multiplier.
- `mm_mpand`  out  W  multiplicand.
- `mm_mplier`  out  W  multiplier.
- `mm_modulus`  out  W  modulus. Equals the latched N.
- `mm_ready`  in  1  multiplier idle / product valid.
- `mm_product`  in  W  multiplier result.

## Operation
- Reset: IDLE; `busy`=0, `done`=0, `result`=0, `mm_ds`=0, all internal registers cleared.
- IDLE: when `start`=1, latch `base`→M, `exponent`→E, `modulus`→N, set bit counter `cnt`=EW, then go to SCAN.
- SCAN: one bit per cycle.
  - If `cnt`==0 (exponent was zero): R=1, go to DONE.
  - Else if E[EW-1]=1: R=M, shift E left by 1, `cnt`-=1. Go to DONE if `cnt` is now 0, else SQ_ISSUE.
  - Else shift E left by 1 and `cnt`-=1.
- SQ_ISSUE: `mm_mpand`=`mm_mplier`=R. `mm_ds` is asserted combinationally only while `mm_ready`=1; go to SQ_WAIT in that cycle. While `mm_ready`=0, stay and keep `mm_ds`=0.
- SQ_WAIT: the first cycle is a guard cycle, and `mm_ready` is ignored there. After the guard, when `mm_ready`=1, capture R=`mm_product`.
  - If E[EW-1]=1, go to MUL_ISSUE.
  - Else go to NEXT.
- MUL_ISSUE / MUL_WAIT: identical handshake with `mm_mpand`=R and `mm_mplier`=M, then go to NEXT.
- NEXT: shift E left by 1, `cnt`-=1. Go to DONE if `cnt`==0, else SQ_ISSUE.
- DONE: `result`=R, `done`=1 for one cycle, `busy`=0 next cycle, return to IDLE.
- Operand ports (`mm_mpand`, `mm_mplier`, `mm_modulus`) are registered/stable throughout ISSUE and WAIT. `mm_ds` is never high outside the ISSUE states and never for two consecutive cycles.
- `start` while busy is ignored. No queueing.
- Widths:
  - R, M, N are W bits.
  - `cnt` is clog2(EW+1) bits and must never wrap below 0.
  - All arithmetic is done in the multiplier. This block only selects and moves data.

## Timing
- `start` accepted in cycle t; `busy`=1 from t+1.
- SCAN takes (EW − position of the top set bit) cycles, or EW+1 cycles for a zero exponent.
- Each multiplication costs 1 ISSUE cycle (plus any stall while `mm_ready`=0), the multiplier latency L (≈ index of the top set bit of `mm_mplier` + 2 cycles), and 1 capture cycle.
- Total multiplications = (bit length of exponent − 1) + (popcount − 1).
- `done` is asserted the cycle after the final capture or SCAN exit. `result` is valid from that cycle.
- `rst` mid-operation forces IDLE on the next edge with all outputs at reset values. Because ISSUE waits on `mm_ready`, a multiplier still running its old job is waited out safely.

## Structure
- Shared package `rsa_pkg`: default W/EW constants and the state enum (IDLE, SCAN, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, NEXT, DONE).
- No sub-module. One FSM plus E/R/M/N/`cnt` registers.
- The multiplier is instantiated in the parent top, with reset polarity adapted there.

## Test plan
Use W=EW=16 unless stated, with a behavioural or real multiplier.
- Basic: base=4, exp=13, mod=497 → `result`=445. Exactly 5 `mm_ds` pulses; `done` is a single pulse.
- Zero exponent: base=5, exp=0, mod=7 → `result`=1, `done` after EW+1 SCAN cycles, zero `mm_ds` pulses.
- Unit exponent: base=6, exp=1, mod=11 → `result`=6, zero `mm_ds` pulses.
- Handshake stall: exp=2, base=3, mod=7 with `mm_ready` forced low for 20 cycles in SQ_ISSUE → no `mm_ds` until release; `result`=2. Additionally, `start` pulsed while `busy` → ignored, `result` still 2.
- Reset mid-run: assert `rst` during SQ_WAIT → next cycle `busy`=0, `done`=0, `result`=0. A subsequent run with base=4, exp=13, mod=497 still gives 445.
- Full width: W=EW=1024, random odd modulus, e=65537 and random d → `result` matches the software modpow. Encrypt-then-decrypt round-trip returns the original message.
